// File: rtl/snes_pad_reader.sv
// Console-side poller for an NES/SNES serial pad: drives latch and pad clock, samples the
// synchronized data line MSB-first and presents each completed frame with a one-cycle strobe.
module snes_pad_reader #(
  parameter int unsigned NUM_BITS    = 16,
  parameter int unsigned LATCH_LEN   = 12,
  parameter int unsigned HALF_PERIOD = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pad_data,
  output logic                latch_out,
  output logic                pad_clk,
  output logic                busy,
  output logic [NUM_BITS-1:0] frame_out,
  output logic                frame_valid
);

  localparam int unsigned PhaseMax = (LATCH_LEN > HALF_PERIOD) ? LATCH_LEN : HALF_PERIOD;
  localparam int unsigned PhW      = $clog2(PhaseMax) + 1;
  localparam int unsigned BitW     = $clog2(NUM_BITS) + 1;

  typedef enum logic [1:0] {StIdle, StLatch, StHigh, StLow} state_e;

  state_e              state_q;
  logic [PhW-1:0]      phase_q;
  logic [BitW-1:0]     bits_q;
  logic [1:0]          sync_q;
  logic [NUM_BITS-1:0] cap_q;
  logic [NUM_BITS-1:0] frame_q;
  logic                latch_q;
  logic                pclk_q;
  logic                busy_q;
  logic                valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      bits_q  <= '0;
      sync_q  <= 2'b11;
      cap_q   <= '1;
      frame_q <= '1;
      latch_q <= 1'b0;
      pclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pad_data};
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLatch;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
            phase_q <= '0;
          end
        end
        StLatch: begin
          if (phase_q == PhW'(LATCH_LEN - 1)) begin
            state_q <= StHigh;
            latch_q <= 1'b0;
            phase_q <= '0;
            bits_q  <= '0;
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StHigh: begin
          // Last high cycle: sample just before the falling edge we are about to drive.
          if (phase_q == PhW'(HALF_PERIOD - 1)) begin
            state_q <= StLow;
            pclk_q  <= 1'b0;
            phase_q <= '0;
            cap_q   <= {cap_q[NUM_BITS-2:0], sync_q[1]};
            bits_q  <= bits_q + BitW'(1);
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StLow: begin
          if (phase_q == PhW'(HALF_PERIOD - 1)) begin
            pclk_q  <= 1'b1;
            phase_q <= '0;
            if (bits_q == BitW'(NUM_BITS)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              frame_q <= cap_q;
              valid_q <= 1'b1;
            end else begin
              state_q <= StHigh;
            end
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign latch_out   = latch_q;
  assign pad_clk     = pclk_q;
  assign busy        = busy_q;
  assign frame_out   = frame_q;
  assign frame_valid = valid_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: three instances (16, 32, 8 bits), each with a shift-register pad and
// a timeline model derived from the poll start cycle, checked every cycle plus directed pins.
module tb_snes_pad_reader;

  localparam int LL = 12;
  localparam int HP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rstn, start, lat, pclk, busy, fv, pdat;
  logic [31:0] fo [3];
  logic [31:0] pad_word [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", g, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 16 : (g == 1) ? 32 : 8;
    localparam int T  = LL + 2 * HP * NB;

    logic [NB-1:0] fo_l;
    logic [NB-1:0] psr = '1;

    snes_pad_reader #(
      .NUM_BITS   (NB),
      .LATCH_LEN  (LL),
      .HALF_PERIOD(HP)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rstn[g]),
      .start      (start[g]),
      .pad_data   (pdat[g]),
      .latch_out  (lat[g]),
      .pad_clk    (pclk[g]),
      .busy       (busy[g]),
      .frame_out  (fo_l),
      .frame_valid(fv[g])
    );

    assign fo[g]   = 32'(fo_l);
    assign pdat[g] = psr[NB-1];

    // Pad: parallel load while latched, shift MSB-first on each pad clock rise, fill with ones.
    always @(posedge lat[g] or posedge pclk[g]) begin
      if (lat[g]) psr <= pad_word[g][NB-1:0];
      else        psr <= {psr[NB-2:0], 1'b1};
    end

    // Model: pos counts edges since the accepting edge; a poll occupies T cycles.
    bit            act = 1'b0;
    int            pos = 0;
    bit            fv_e = 1'b0;
    logic [NB-1:0] fr_e = '1;
    logic [NB-1:0] word_q = '1;

    always @(posedge clk or negedge rstn[g]) begin
      if (!rstn[g]) begin
        act  = 1'b0;
        pos  = 0;
        fv_e = 1'b0;
        fr_e = '1;
      end else begin
        fv_e = 1'b0;
        if (act) begin
          pos++;
          if (pos == T) begin
            act  = 1'b0;
            fv_e = 1'b1;
            fr_e = word_q;
          end
        end else if (start[g]) begin
          act    = 1'b1;
          pos    = 0;
          word_q = pad_word[g][NB-1:0];
        end
      end
    end

    always @(negedge clk) begin
      int   dd;
      logic lat_e, pclk_e;
      dd     = pos + 1;
      lat_e  = act && (dd <= LL);
      pclk_e = !(act && (dd > LL) && ((((dd - LL - 1) / HP) % 2) == 1));
      chk(g, "latch_out", 32'(lat[g]), 32'(lat_e));
      chk(g, "pad_clk", 32'(pclk[g]), 32'(pclk_e));
      chk(g, "busy", 32'(busy[g]), 32'(act));
      chk(g, "frame_valid", 32'(fv[g]), 32'(fv_e));
      chk(g, "frame_out", fo[g], 32'(fr_e));
      chk(g, "latch_with_clk_low", 32'(lat[g] & ~pclk[g]), 32'd0);
    end
  end

  task automatic poll(input int g, input logic [31:0] w, output int fv_at, output int lat_n,
                      output int fall_n, output int low_n);
    logic prev;
    pad_word[g] = w;
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    fv_at = -1; lat_n = 0; fall_n = 0; low_n = 0; prev = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      if (lat[g]) lat_n++;
      if (!pclk[g]) low_n++;
      if (prev && !pclk[g]) fall_n++;
      prev = pclk[g];
      if (fv[g]) begin
        fv_at = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int fv_at, lat_n, fall_n, low_n, fvc, drop, t1, t2, cnt;
    rstn  = '0;
    start = '0;
    for (int g = 0; g < 3; g++) pad_word[g] = '1;
    repeat (3) @(negedge clk);
    #2 rstn = '1;
    @(negedge clk);
    chk(0, "rst_frame_out", fo[0], 32'h0000_FFFF);
    chk(0, "rst_pad_clk", 32'(pclk[0]), 32'd1);

    // Defaults with 16'hA5F0.
    poll(0, 32'h0000_A5F0, fv_at, lat_n, fall_n, low_n);
    chk(0, "fv_cycle", 32'(fv_at), 32'd205);
    chk(0, "latch_len", 32'(lat_n), 32'd12);
    chk(0, "clk_falls", 32'(fall_n), 32'd16);
    chk(0, "clk_low_cycles", 32'(low_n), 32'd96);
    chk(0, "frame_a5f0", fo[0], 32'h0000_A5F0);

    // Disconnected 32-bit pad.
    poll(1, 32'hFFFF_FFFF, fv_at, lat_n, fall_n, low_n);
    chk(1, "fv_cycle", 32'(fv_at), 32'd397);
    chk(1, "clk_falls", 32'(fall_n), 32'd32);
    chk(1, "frame_ones", fo[1], 32'hFFFF_FFFF);

    // 8-bit pad.
    poll(2, 32'h0000_005A, fv_at, lat_n, fall_n, low_n);
    chk(2, "fv_cycle", 32'(fv_at), 32'(LL + 97));
    chk(2, "frame_5a", fo[2], 32'h0000_005A);

    // Second start at k+50 is ignored.
    pad_word[0] = 32'h0000_1234;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    fvc = 0; drop = 0;
    for (int n = 1; n <= 450; n++) begin
      if (n == 50) start[0] = 1'b1;
      if (n == 51) start[0] = 1'b0;
      if (fvc == 0 && !fv[0] && !busy[0]) drop++;
      if (fv[0]) fvc++;
      @(negedge clk);
    end
    chk(0, "fv_count_busy", 32'(fvc), 32'd1);
    chk(0, "busy_early_drop", 32'(drop), 32'd0);
    chk(0, "frame_1234", fo[0], 32'h0000_1234);

    // Start held: back-to-back polls.
    start[0] = 1'b1;
    cnt = 0; t1 = -1; t2 = -1;
    for (int n = 0; n <= 1000; n++) begin
      @(negedge clk);
      if (fv[0]) begin
        if (cnt == 0) begin
          t1 = n;
          chk(0, "b2b_frame1", fo[0], 32'h0000_1234);
          pad_word[0] = 32'h0000_FFFE;
        end else begin
          t2 = n;
          chk(0, "b2b_frame2", fo[0], 32'h0000_FFFE);
          start[0] = 1'b0;
          break;
        end
        cnt++;
      end
    end
    chk(0, "b2b_gap", 32'(t2 - t1), 32'd205);

    // Reset mid-capture at k+100.
    poll(0, 32'h0000_3C3C, fv_at, lat_n, fall_n, low_n);
    pad_word[0] = 32'h0000_C3C3;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (99) @(negedge clk);
    #2 rstn[0] = 1'b0;
    #1;
    chk(0, "rst_mid_latch", 32'(lat[0]), 32'd0);
    chk(0, "rst_mid_pad_clk", 32'(pclk[0]), 32'd1);
    chk(0, "rst_mid_busy", 32'(busy[0]), 32'd0);
    chk(0, "rst_mid_frame", fo[0], 32'h0000_FFFF);
    fvc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fv[0]) fvc++;
    end
    chk(0, "rst_no_fv", 32'(fvc), 32'd0);
    #2 rstn[0] = 1'b1;
    poll(0, 32'h0000_00FF, fv_at, lat_n, fall_n, low_n);
    chk(0, "post_rst_fv", 32'(fv_at), 32'd205);
    chk(0, "post_rst_frame", fo[0], 32'h0000_00FF);

    // Random starts, pad words and occasional resets on all instances.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        start[g] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) pad_word[g] = $urandom;
      end
      if ($urandom_range(0, 1499) == 0) begin
        #2 rstn = '0;
        @(negedge clk);
        #2 rstn = '1;
      end
    end
    start = '0;
    repeat (450) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
